// File: rtl/button_conditioner_pkg.sv
// ui_pkg: button indices and repeat-FSM states shared by the button consumers
package ui_pkg;
    localparam int BTN_C    = 0;
    localparam int BTN_L    = 1;
    localparam int BTN_R    = 2;
    localparam int BTN_U    = 3;
    localparam int BTN_D    = 4;
    localparam int NUM_BTNS = 5;
    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rep_state_e;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button pins in, conditioned levels and pulses out
interface button_conditioner_if;
    logic [ui_pkg::NUM_BTNS-1:0] btn_raw, btn_debounced, btn_press, btn_event;
    modport master (output btn_raw, input btn_debounced, btn_press, btn_event);
    modport slave  (input btn_raw, output btn_debounced, btn_press, btn_event);
endinterface

// File: rtl/button_conditioner_debounce_cell.sv
// debounce_cell: two-flop synchroniser, stable-count debouncer and press pulse for one button
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic debounced,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d, press_q, press_d;
    always_comb begin
        sync_d  = {sync_q[0], raw};
        cnt_d   = (sync_q[1] == deb_q || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        deb_d   = (sync_q[1] != deb_q && cnt_q == CNT_MAX) ? ~deb_q : deb_q;
        press_d = deb_d & ~deb_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
        end
    end
    assign debounced = deb_q;
    assign press     = press_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: five-button sync/debounce front end with press and auto-repeat events
module button_conditioner
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input logic                 clk,
    input logic                 reset_n,
    button_conditioner_if.slave bus
);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] DELAY_END  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_END = TW'(REPEAT_PERIOD - 1);
    logic [NUM_BTNS-1:0] deb, press, rep;
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw      (bus.btn_raw[i]),
            .debounced(deb[i]),
            .press    (press[i])
        );
    end
    assign rep[BTN_C] = 1'b0;
    for (genvar i = BTN_L; i < NUM_BTNS; i++) begin : g_rep
        rep_state_e    state_q, state_d;
        logic [TW-1:0] tmr_q, tmr_d;
        logic          hit;
        assign hit    = (state_q == RPT_DELAY  && tmr_q == DELAY_END) ||
                        (state_q == RPT_REPEAT && tmr_q == PERIOD_END);
        // gating by the level suppresses a pulse in the cycle the button reads released
        assign rep[i] = deb[i] & hit;
        always_comb begin
            state_d = !deb[i]              ? RPT_IDLE :
                      state_q == RPT_IDLE  ? (press[i] ? RPT_DELAY : RPT_IDLE) :
                      hit                  ? RPT_REPEAT : state_q;
            tmr_d   = (!deb[i] || state_q == RPT_IDLE || hit) ? '0 : tmr_q + 1'b1;
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= RPT_IDLE;
                tmr_q   <= '0;
            end else begin
                state_q <= state_d;
                tmr_q   <= tmr_d;
            end
        end
    end
    assign bus.btn_debounced = deb;
    assign bus.btn_press     = press;
    assign bus.btn_event     = press | rep;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table, hand-written and random checks against a window/arithmetic model
module tb_button_conditioner;
    import ui_pkg::*;
    localparam int D = 4, RD = 10, RP = 3;

    typedef struct {
        logic [4:0] pat;
        int         len;
        logic [4:0] deb_end;
        int         presses;
        int         events;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if bus();
    button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [4:0] hist[$];
    logic [4:0] m_deb, m_press, m_evt;
    int         press_at[NUM_BTNS];
    int         cyc = -1;
    int         checks = 0, errors = 0;
    vec_t       vecs[7];
    int         np, ne, pc, cnt, any_hi, ev_after;
    int         evq[$];
    logic [4:0] de, snap, r;

    function automatic logic [4:0] raw_at(input int j);
        return (j < 0) ? 5'b0 : hist[j];
    endfunction

    // Level flips once sync has disagreed with it for D consecutive cycles;
    // sync(c) is the raw value sampled at edge c-1.
    task automatic model_edge();
        logic [4:0] old, w;
        logic       diff;
        int         h;
        old = m_deb;
        cyc = hist.size() - 1;
        for (int b = 0; b < NUM_BTNS; b++) begin
            diff = 1'b1;
            for (int j = cyc - D - 1; j <= cyc - 2; j++) begin
                w = raw_at(j);
                if (w[b] == old[b]) diff = 1'b0;
            end
            m_deb[b]   = diff ? ~old[b] : old[b];
            m_press[b] = m_deb[b] & ~old[b];
            if (m_press[b]) press_at[b] = cyc;
            h = cyc - press_at[b];
            m_evt[b] = m_press[b] | (b != BTN_C && m_deb[b] && h >= RD && (h - RD) % RP == 0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [4:0] rv);
        bus.btn_raw = rv;
        @(posedge clk);
        hist.push_back(rv);
        model_edge();
        #1;
        chk("debounced", int'(bus.btn_debounced), int'(m_deb));
        chk("press", int'(bus.btn_press), int'(m_press));
        chk("event", int'(bus.btn_event), int'(m_evt));
    endtask

    task automatic apply_reset(input logic [4:0] rv);
        #2 reset_n = 1'b0;
        bus.btn_raw = rv;
        #1;
        chk("reset_debounced", int'(bus.btn_debounced), 0);
        chk("reset_press", int'(bus.btn_press), 0);
        chk("reset_event", int'(bus.btn_event), 0);
        hist.delete();
        m_deb   = '0;
        m_press = '0;
        m_evt   = '0;
        cyc     = -1;
        for (int b = 0; b < NUM_BTNS; b++) press_at[b] = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{5'b00100, 20, 5'b00100, 1, 5};
        vecs[1] = '{5'b00001, 40, 5'b00001, 1, 1};
        vecs[2] = '{5'b00010, 40, 5'b00010, 1, 11};
        vecs[3] = '{5'b11000,  5, 5'b00000, 2, 2};
        vecs[4] = '{5'b00010,  3, 5'b00000, 0, 0};
        vecs[5] = '{5'b10000,  4, 5'b00000, 1, 1};
        vecs[6] = '{5'b11111, 15, 5'b11111, 5, 13};
        bus.btn_raw = '0;
        apply_reset(5'b0);

        for (int v = 0; v < 7; v++) begin
            apply_reset(5'b0);
            np = 0;
            ne = 0;
            for (int k = 0; k < vecs[v].len; k++) begin
                step(vecs[v].pat);
                np += $countones(bus.btn_press);
                ne += $countones(bus.btn_event);
            end
            de = bus.btn_debounced;
            for (int k = 0; k < 12; k++) begin
                step(5'b0);
                np += $countones(bus.btn_press);
                ne += $countones(bus.btn_event);
            end
            chk($sformatf("vec%0d_deb_end", v), int'(de), int'(vecs[v].deb_end));
            chk($sformatf("vec%0d_presses", v), np, vecs[v].presses);
            chk($sformatf("vec%0d_events", v), ne, vecs[v].events);
        end

        apply_reset(5'b0);
        pc = -1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            r = '0;
            r[0] = (k >= 4) || (k % 2 == 0);
            step(r);
            if (bus.btn_press[0]) begin
                cnt++;
                pc = cyc;
            end
        end
        chk("bounce_press_count", cnt, 1);
        chk("bounce_press_cycle", pc, 9);

        apply_reset(5'b0);
        any_hi = 0;
        for (int k = 0; k < 13; k++) begin
            step((k < 3) ? 5'b00001 : 5'b00000);
            any_hi |= int'(bus.btn_debounced[0]);
        end
        chk("glitch_level", any_hi, 0);

        apply_reset(5'b0);
        evq.delete();
        for (int k = 0; k < 55; k++) begin
            step((k < 40) ? 5'b00010 : 5'b00000);
            if (bus.btn_event[1]) evq.push_back(cyc);
        end
        chk("repeat_count", evq.size(), 11);
        chk("repeat_first", (evq.size() > 0) ? evq[0] : -1, 5);
        chk("repeat_second", (evq.size() > 1) ? evq[1] : -1, 15);
        chk("repeat_third", (evq.size() > 2) ? evq[2] : -1, 18);
        chk("repeat_last", (evq.size() > 0) ? evq[evq.size()-1] : -1, 42);

        apply_reset(5'b0);
        snap = '0;
        for (int k = 0; k < 8; k++) begin
            step(5'b11000);
            if (cyc == 5) snap = bus.btn_press;
        end
        chk("simultaneous_press", int'(snap), int'(5'b11000));

        apply_reset(5'b0);
        for (int k = 0; k < 20; k++) step(5'b00010);
        chk("pre_reset_level", int'(bus.btn_debounced), int'(5'b00010));
        apply_reset(5'b00010);
        pc = -1;
        ev_after = -1;
        for (int k = 0; k < 20; k++) begin
            step(5'b00010);
            if (bus.btn_press[1] && pc < 0) pc = cyc;
            else if (bus.btn_event[1] && pc >= 0 && ev_after < 0) ev_after = cyc;
        end
        chk("reset_repress_cycle", pc, 5);
        chk("reset_first_repeat", ev_after, 15);

        apply_reset(5'b0);
        r = '0;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < NUM_BTNS; b++)
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            if (k == 300) apply_reset(r);
            step(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
